pipeline_ctrl: RTL and testbench

Central sequencer for the five-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It generates every latch enable and flush and implements the run/step/halt execution modes driven by the debug unit. It also detects load-use hazards and taken branches/jumps, and keeps cycle and stall counters for debug readout.

---
 rtl/pipeline_ctrl.sv | 88 ++++++++
 tb/tb_pipeline_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the five-stage MIPS core: latch enables/flushes,
// run/step/halt execution modes, load-use hazard stall and debug counters.
module pipeline_ctrl #(
   parameter int W  = 5,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic          step,
   input  logic          halt_wb,
   input  logic          id_ex_mem_read,
   input  logic [W-1:0]  id_ex_rt,
   input  logic [W-1:0]  if_id_rs,
   input  logic [W-1:0]  if_id_rt,
   input  logic          branch_taken,
   output logic          pc_ena,
   output logic          if_id_ena,
   output logic          if_id_flush,
   output logic          id_ex_ena,
   output logic          id_ex_flush,
   output logic          ex_mem_ena,
   output logic          mem_wb_ena,
   output logic [1:0]    state,
   output logic [CW-1:0] cycle_count,
   output logic [CW-1:0] stall_count
);

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] RUN    = 2'b01;
   localparam logic [1:0] STEP   = 2'b10;
   localparam logic [1:0] HALTED = 2'b11;

   logic step_q;
   logic step_rise;
   logic advance;
   logic hazard;

   always_comb begin
      step_rise = step & ~step_q;
      advance   = (state == RUN) | ((state == STEP) & step_rise);
      hazard    = id_ex_mem_read & (id_ex_rt != '0) &
                  ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
   end

   // Hazard wins over branch: the stalled branch is re-evaluated on the next advance.
   assign ex_mem_ena  = advance;
   assign mem_wb_ena  = advance;
   assign id_ex_ena   = advance;
   assign pc_ena      = advance & ~hazard;
   assign if_id_ena   = advance & ~hazard;
   assign id_ex_flush = advance & hazard;
   assign if_id_flush = advance & ~hazard & branch_taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         step_q      <= 1'b0;
         cycle_count <= '0;
         stall_count <= '0;
      end else begin
         step_q <= step;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= mode ? STEP : RUN;
                  cycle_count <= '0;
                  stall_count <= '0;
               end
            end
            RUN, STEP: begin
               if (advance) begin
                  if (cycle_count != '1)
                     cycle_count <= cycle_count + CW'(1);
                  if (hazard && (stall_count != '1))
                     stall_count <= stall_count + CW'(1);
                  if (halt_wb)
                     state <= HALTED;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a behavioural model;
// a second instance with CW=4 exercises counter saturation.
module tb_pipeline_ctrl;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         reset, start, mode, step, halt_wb;
   logic         id_ex_mem_read, branch_taken;
   logic [W-1:0] id_ex_rt, if_id_rs, if_id_rt;

   logic         pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush, ex_mem_ena, mem_wb_ena;
   logic [1:0]   state;
   logic [31:0]  cycle_count, stall_count;

   logic         pc_ena4, if_id_ena4, if_id_flush4, id_ex_ena4, id_ex_flush4, ex_mem_ena4, mem_wb_ena4;
   logic [1:0]   state4;
   logic [3:0]   cycle_count4, stall_count4;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // reference model (state numbers follow the published encoding)
   int          m_state;
   bit          m_step_prev;
   longint      m_cyc, m_stall, m_cyc4, m_stall4;

   always #5 clk = ~clk;

   pipeline_ctrl #(.W(W), .CW(32)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .step(step),
      .halt_wb(halt_wb), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
      .pc_ena(pc_ena), .if_id_ena(if_id_ena), .if_id_flush(if_id_flush),
      .id_ex_ena(id_ex_ena), .id_ex_flush(id_ex_flush), .ex_mem_ena(ex_mem_ena),
      .mem_wb_ena(mem_wb_ena), .state(state), .cycle_count(cycle_count),
      .stall_count(stall_count)
   );

   pipeline_ctrl #(.W(W), .CW(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .step(step),
      .halt_wb(halt_wb), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
      .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
      .pc_ena(pc_ena4), .if_id_ena(if_id_ena4), .if_id_flush(if_id_flush4),
      .id_ex_ena(id_ex_ena4), .id_ex_flush(id_ex_flush4), .ex_mem_ena(ex_mem_ena4),
      .mem_wb_ena(mem_wb_ena4), .state(state4), .cycle_count(cycle_count4),
      .stall_count(stall_count4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic longint sat_inc(input longint v, input longint max);
      return (v >= max) ? max : v + 1;
   endfunction

   task automatic idle_inputs();
      reset = 0; start = 0; mode = 0; step = 0; halt_wb = 0;
      id_ex_mem_read = 0; branch_taken = 0;
      id_ex_rt = '0; if_id_rs = '0; if_id_rt = '0;
   endtask

   // One clock: compare combinational outputs mid-cycle, then advance the model at the edge.
   task automatic tick();
      bit adv, haz, running;
      logic [6:0] exp_en;
      @(negedge clk);
      running = (m_state == 1) || (m_state == 2);
      adv = (m_state == 1) || (m_state == 2 && step && !m_step_prev);
      haz = id_ex_mem_read && (id_ex_rt != 0) &&
            ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
      exp_en = {adv && !haz, adv && !haz, adv && !haz && branch_taken,
                adv, adv && haz, adv, adv};
      check("state", state, m_state);
      check("enables", {pc_ena, if_id_ena, if_id_flush, id_ex_ena, id_ex_flush,
                        ex_mem_ena, mem_wb_ena}, exp_en);
      check("enables_cw4", {pc_ena4, if_id_ena4, if_id_flush4, id_ex_ena4, id_ex_flush4,
                            ex_mem_ena4, mem_wb_ena4}, exp_en);
      check("cycle_count", cycle_count, m_cyc);
      check("stall_count", stall_count, m_stall);
      check("cycle_count_cw4", cycle_count4, m_cyc4);
      check("stall_count_cw4", stall_count4, m_stall4);
      @(posedge clk);
      if (reset) begin
         m_state = 0; m_step_prev = 0;
         m_cyc = 0; m_stall = 0; m_cyc4 = 0; m_stall4 = 0;
      end else begin
         m_step_prev = step;
         if (m_state == 0 && start) begin
            m_state = mode ? 2 : 1;
            m_cyc = 0; m_stall = 0; m_cyc4 = 0; m_stall4 = 0;
         end else if (running && adv) begin
            m_cyc  = sat_inc(m_cyc, 64'hFFFF_FFFF);
            m_cyc4 = sat_inc(m_cyc4, 15);
            if (haz) begin
               m_stall  = sat_inc(m_stall, 64'hFFFF_FFFF);
               m_stall4 = sat_inc(m_stall4, 15);
            end
            if (halt_wb) m_state = 3;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic start_mode(input bit md);
      idle_inputs();
      start = 1; mode = md;
      tick();
      start = 0;
   endtask

   initial begin
      m_state = 0; m_step_prev = 0;
      m_cyc = 0; m_stall = 0; m_cyc4 = 0; m_stall4 = 0;
      idle_inputs();
      #1;
      reset = 1;
      @(posedge clk); #1;
      do_reset();

      // idle, then RUN
      repeat (5) tick();
      check("idle_state", state, 2'b00);
      start_mode(0);
      tick();
      check("run_state", state, 2'b01);

      // load-use stall, rt=0 non-stall, branch alone and under stall
      id_ex_mem_read = 1; id_ex_rt = 8; if_id_rs = 8;
      tick();
      check("stall_once", stall_count, 1);
      id_ex_rt = 0; if_id_rs = 0;
      tick();
      id_ex_mem_read = 0; branch_taken = 1;
      tick();
      id_ex_mem_read = 1; id_ex_rt = 3; if_id_rt = 3;
      tick();
      idle_inputs();

      // halt at cycle_count 20; start afterwards must be ignored
      while (m_cyc < 20 && m_state == 1) tick();
      halt_wb = 1;
      tick();
      halt_wb = 0;
      check("halted_state", state, 2'b11);
      check("halt_cycles", cycle_count, 21);
      check("sat_cw4", cycle_count4, 15);
      start = 1;
      repeat (4) tick();
      check("halted_sticky", state, 2'b11);

      // STEP: three long pulses yield three advances, start cycle step ignored
      do_reset();
      idle_inputs();
      start = 1; mode = 1; step = 1;
      tick();
      start = 0; step = 0;
      tick();
      for (int p = 0; p < 3; p++) begin
         step = 1; repeat (10) tick();
         step = 0; repeat (3) tick();
      end
      check("step_three", cycle_count, 3);

      // reset mid-run
      do_reset();
      start_mode(0);
      repeat (7) tick();
      reset = 1;
      tick();
      reset = 0;
      tick();
      check("reset_mid_run", state, 2'b00);

      // randomized episodes
      for (int e = 0; e < 40; e++) begin
         do_reset();
         repeat ($urandom_range(0, 2)) tick();
         start_mode(1'($urandom_range(0, 1)));
         for (int c = 0; c < 60; c++) begin
            step           = 1'($urandom_range(0, 1));
            id_ex_mem_read = 1'($urandom_range(0, 1));
            id_ex_rt       = W'($urandom_range(0, 3));
            if_id_rs       = W'($urandom_range(0, 3));
            if_id_rt       = W'($urandom_range(0, 3));
            branch_taken   = 1'($urandom_range(0, 1));
            halt_wb        = ($urandom_range(0, 49) == 0);
            start          = 1'($urandom_range(0, 1));
            mode           = 1'($urandom_range(0, 1));
            reset          = ($urandom_range(0, 99) == 0);
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
